// File: rtl/sram_arb_pkg.sv
// Shared definitions for the sram request arbiter.
//   OWNER_*  : owner tag stored per accepted request (which side gets the response)
//   SIZE_*   : sram access size codes
//   sram_req_t : bundle of the request fields muxed onto the memory port
package sram_arb_pkg;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_req_arbiter_owner_fifo.sv
// In-order owner FIFO, 1 bit wide.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write din at the tail (ignored when full)
//   pop        : advance the head (ignored when empty)
//   dout       : current head entry
//   full, empty, count : occupancy status; count has one extra bit
module owner_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     din,
    input  logic                     pop,
    output logic                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        // Pointers wrap naturally since DEPTH is a power of two.
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (cnt_q == (PW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one sram-like memory port between instruction fetch (inst) and load/store (data).
//   inst_sram_* / data_sram_* : requester ports (req/wr/size/wstrb/addr/wdata in,
//                               addr_ok/data_ok/rdata out)
//   mem_*                     : downstream request out, mem_addr_ok/mem_data_ok/mem_rdata in
//   outst_cnt                 : accepted-but-unanswered request count
//   err_stray_ok              : sticky, set by a response arriving with nothing outstanding
// Data wins arbitration unless inst has waited through STARVE_LIMIT data grants.
// Each accepted request's owner is queued so in-order responses route back correctly.
module sram_req_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned OUTST_DEPTH  = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         inst_sram_req,
    input  logic                         inst_sram_wr,
    input  logic [1:0]                   inst_sram_size,
    input  logic [3:0]                   inst_sram_wstrb,
    input  logic [31:0]                  inst_sram_addr,
    input  logic [31:0]                  inst_sram_wdata,
    output logic                         inst_sram_addr_ok,
    output logic                         inst_sram_data_ok,
    output logic [31:0]                  inst_sram_rdata,
    input  logic                         data_sram_req,
    input  logic                         data_sram_wr,
    input  logic [1:0]                   data_sram_size,
    input  logic [3:0]                   data_sram_wstrb,
    input  logic [31:0]                  data_sram_addr,
    input  logic [31:0]                  data_sram_wdata,
    output logic                         data_sram_addr_ok,
    output logic                         data_sram_data_ok,
    output logic [31:0]                  data_sram_rdata,
    output logic                         mem_req,
    output logic                         mem_wr,
    output logic [1:0]                   mem_size,
    output logic [3:0]                   mem_wstrb,
    output logic [31:0]                  mem_addr,
    output logic [31:0]                  mem_wdata,
    input  logic                         mem_addr_ok,
    input  logic                         mem_data_ok,
    input  logic [31:0]                  mem_rdata,
    output logic [$clog2(OUTST_DEPTH):0] outst_cnt,
    output logic                         err_stray_ok
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0]               starve_q, starve_d;
    logic                        err_stray_q, err_stray_d;
    logic                        sel_data, sel_inst, fire, pop;
    logic                        fifo_full, fifo_empty, fifo_head;
    logic [$clog2(OUTST_DEPTH):0] fifo_count;
    sram_req_t                   inst_r, data_r, mem_r;

    assign inst_r = '{wr: inst_sram_wr, size: inst_sram_size, wstrb: inst_sram_wstrb,
                      addr: inst_sram_addr, wdata: inst_sram_wdata};
    assign data_r = '{wr: data_sram_wr, size: data_sram_size, wstrb: data_sram_wstrb,
                      addr: data_sram_addr, wdata: data_sram_wdata};

    always_comb begin
        sel_data = 1'b0;
        sel_inst = 1'b0;
        // Full blocks new requests even if a pop lands this cycle, keeping
        // mem_data_ok off the mem_req path.
        if (!reset && !fifo_full) begin
            sel_data = data_sram_req && !(inst_sram_req && starve_q == SW'(STARVE_LIMIT));
            sel_inst = inst_sram_req && !sel_data;
        end
        mem_r = sel_data ? data_r : (sel_inst ? inst_r : '0);
        fire  = (sel_data || sel_inst) && mem_addr_ok;
        pop   = !reset && mem_data_ok && !fifo_empty;

        starve_d = starve_q;
        if (!inst_sram_req || (fire && sel_inst)) begin
            starve_d = '0;
        end else if (fire && sel_data && starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end

        err_stray_d = err_stray_q || (mem_data_ok && fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q    <= '0;
            err_stray_q <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            err_stray_q <= err_stray_d;
        end
    end

    owner_fifo #(
        .DEPTH (OUTST_DEPTH)
    ) u_owner_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fire),
        .din   (sel_data ? OWNER_DATA : OWNER_INST),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign mem_req           = sel_data || sel_inst;
    assign mem_wr            = mem_r.wr;
    assign mem_size          = mem_r.size;
    assign mem_wstrb         = mem_r.wstrb;
    assign mem_addr          = mem_r.addr;
    assign mem_wdata         = mem_r.wdata;
    assign data_sram_addr_ok = sel_data && mem_addr_ok;
    assign inst_sram_addr_ok = sel_inst && mem_addr_ok;
    assign data_sram_data_ok = pop && (fifo_head == OWNER_DATA);
    assign inst_sram_data_ok = pop && (fifo_head == OWNER_INST);
    // rdata is broadcast; consumers qualify it with their data_ok.
    assign inst_sram_rdata   = reset ? '0 : mem_rdata;
    assign data_sram_rdata   = reset ? '0 : mem_rdata;
    assign outst_cnt         = reset ? '0 : fifo_count;
    assign err_stray_ok      = err_stray_q && !reset;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter: directed scenarios plus a randomized run,
// all compared against a queue-based reference model.
module tb_sram_req_arbiter;
    import sram_arb_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req, inst_sram_wr, data_sram_req, data_sram_wr;
    logic [1:0]  inst_sram_size, data_sram_size;
    logic [3:0]  inst_sram_wstrb, data_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata, data_sram_addr, data_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] inst_sram_rdata, data_sram_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  outst_cnt;
    logic        err_stray_ok;

    sram_req_arbiter #(
        .OUTST_DEPTH  (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .mem_req           (mem_req),
        .mem_wr            (mem_wr),
        .mem_size          (mem_size),
        .mem_wstrb         (mem_wstrb),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_addr_ok       (mem_addr_ok),
        .mem_data_ok       (mem_data_ok),
        .mem_rdata         (mem_rdata),
        .outst_cnt         (outst_cnt),
        .err_stray_ok      (err_stray_ok)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: owners of outstanding requests, oldest first.
    logic mq[$];
    int   starve_m = 0;
    logic stray_m  = 1'b0;

    // Observed values from the most recent step, for directed checks.
    logic obs_mem_req, obs_dgrant, obs_igrant, obs_iok, obs_dok, obs_err;
    logic [2:0] obs_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic ireq, input logic dreq,
                         input logic aok, input logic dok);
        reset           = rst;
        inst_sram_req   = ireq;
        data_sram_req   = dreq;
        mem_addr_ok     = aok;
        mem_data_ok     = dok;
        inst_sram_wr    = 1'($urandom_range(0, 1));
        data_sram_wr    = 1'($urandom_range(0, 1));
        inst_sram_size  = SIZE_W;
        data_sram_size  = 2'($urandom_range(SIZE_B, SIZE_W));
        inst_sram_wstrb = 4'($urandom);
        data_sram_wstrb = 4'($urandom);
        inst_sram_addr  = $urandom;
        data_sram_addr  = $urandom;
        inst_sram_wdata = $urandom;
        data_sram_wdata = $urandom;
        mem_rdata       = $urandom;
    endtask

    // Compare every output against the model, advance the model, move past the clock edge.
    task automatic step();
        logic        e_d, e_i, e_fire, e_pop, e_own;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wstrb;
        logic [1:0]  e_size;
        logic        e_wr;
        @(negedge clk);
        e_d = 1'b0;
        e_i = 1'b0;
        if (!reset && mq.size() < DEPTH) begin
            e_d = data_sram_req && !(inst_sram_req && starve_m == LIMIT);
            e_i = inst_sram_req && !e_d;
        end
        e_addr  = e_d ? data_sram_addr  : (e_i ? inst_sram_addr  : 32'h0);
        e_wdata = e_d ? data_sram_wdata : (e_i ? inst_sram_wdata : 32'h0);
        e_wstrb = e_d ? data_sram_wstrb : (e_i ? inst_sram_wstrb : 4'h0);
        e_size  = e_d ? data_sram_size  : (e_i ? inst_sram_size  : 2'h0);
        e_wr    = e_d ? data_sram_wr    : (e_i ? inst_sram_wr    : 1'b0);
        e_fire  = (e_d || e_i) && mem_addr_ok;
        e_pop   = !reset && mem_data_ok && mq.size() > 0;
        e_own   = (mq.size() > 0) ? mq[0] : OWNER_INST;

        check_eq("mem_req", 32'(mem_req), 32'(e_d || e_i));
        check_eq("mem_addr", mem_addr, e_addr);
        check_eq("mem_wdata", mem_wdata, e_wdata);
        check_eq("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
        check_eq("mem_size", 32'(mem_size), 32'(e_size));
        check_eq("mem_wr", 32'(mem_wr), 32'(e_wr));
        check_eq("data_addr_ok", 32'(data_sram_addr_ok), 32'(e_d && mem_addr_ok));
        check_eq("inst_addr_ok", 32'(inst_sram_addr_ok), 32'(e_i && mem_addr_ok));
        check_eq("data_data_ok", 32'(data_sram_data_ok), 32'(e_pop && e_own == OWNER_DATA));
        check_eq("inst_data_ok", 32'(inst_sram_data_ok), 32'(e_pop && e_own == OWNER_INST));
        check_eq("inst_rdata", inst_sram_rdata, reset ? 32'h0 : mem_rdata);
        check_eq("data_rdata", data_sram_rdata, reset ? 32'h0 : mem_rdata);
        check_eq("outst_cnt", 32'(outst_cnt), reset ? 32'h0 : 32'(mq.size()));
        check_eq("err_stray_ok", 32'(err_stray_ok), 32'(stray_m && !reset));

        obs_mem_req = mem_req;
        obs_dgrant  = data_sram_addr_ok;
        obs_igrant  = inst_sram_addr_ok;
        obs_iok     = inst_sram_data_ok;
        obs_dok     = data_sram_data_ok;
        obs_err     = err_stray_ok;
        obs_cnt     = outst_cnt;

        if (reset) begin
            mq.delete();
            starve_m = 0;
            stray_m  = 1'b0;
        end else begin
            if (mem_data_ok && mq.size() == 0) stray_m = 1'b1;
            if (e_pop) void'(mq.pop_front());
            if (e_fire) mq.push_back(e_d ? OWNER_DATA : OWNER_INST);
            if (!inst_sram_req || (e_fire && e_i)) starve_m = 0;
            else if (e_fire && e_d && starve_m < LIMIT) starve_m++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && mq.size() > 0; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            step();
        end
        check_eq("drain_empty", 32'(mq.size()), 32'h0);
    endtask

    initial begin
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        step();

        // Single data request and its response.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        data_sram_addr = 32'h1c00_0100;
        step();
        check_eq("t1_grant", 32'(obs_dgrant), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        mem_rdata = 32'hdead_beef;
        step();
        check_eq("t1_data_ok", 32'(obs_dok), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("t1_cnt", 32'(obs_cnt), 32'h0);

        // Both requesting: data wins LIMIT times, then inst once.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1'(mq.size() > 0));
            step();
            check_eq("starve_seq_d", 32'(obs_dgrant), 32'((i % 5) != 4));
            check_eq("starve_seq_i", 32'(obs_igrant), 32'((i % 5) == 4));
        end
        drain();

        // Inst then data; responses route in order.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check_eq("order_first_i", 32'({obs_iok, obs_dok}), 32'h2);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check_eq("order_second_d", 32'({obs_iok, obs_dok}), 32'h1);

        // Fill to DEPTH, then check the full stall around a pop.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            step();
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        check_eq("full_cnt", 32'(obs_cnt), 32'(DEPTH));
        check_eq("full_no_req", 32'(obs_mem_req), 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        check_eq("full_pop_no_req", 32'(obs_mem_req), 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        check_eq("full_reassert", 32'(obs_mem_req), 32'h1);
        drain();

        // Stray response: sticky until reset.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check_eq("stray_no_ok", 32'({obs_iok, obs_dok}), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("stray_set", 32'(obs_err), 32'h1);
        step();
        check_eq("stray_sticky", 32'(obs_err), 32'h1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("stray_cleared", 32'(obs_err), 32'h0);

        // Reset with three outstanding, then a clean transaction.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            step();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        check_eq("rst_cnt_cleared", 32'(obs_cnt), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check_eq("rst_then_route", 32'({obs_iok, obs_dok}), 32'h2);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 63) == 0),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 9) < 7),
                  1'((mq.size() > 0) && ($urandom_range(0, 1) == 1)));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
